// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, forward-select codes and register-match helpers.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StStall = 1'b1
    } state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] rd,
                                       input logic                  we,
                                       input logic [REG_ADDR_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic id_match(input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  we,
                                      input logic [REG_ADDR_W-1:0] rs1,
                                      input logic                  use1,
                                      input logic [REG_ADDR_W-1:0] rs2,
                                      input logic                  use2);
        return (use1 && reg_match(rd, we, rs1)) || (use2 && reg_match(rd, we, rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller: register fields in,
// stage enables/flushes and EX operand forward selects out.
interface pipeline_hazard_controller_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic                  branch_taken;

    logic                  pc_enable;
    logic                  if_id_enable;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    fwd_sel_t              fwd_a;
    fwd_sel_t              fwd_b;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               branch_taken,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               branch_taken,
        output pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b
    );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational RAW hazard detection: required stall cycles and EX forward selects.
// PIPE_FORWARDING_EN enables forwarding, leaving only the load-use stall.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 2
) (
    input  logic [REG_ADDR_W-1:0]  id_rs1_i,
    input  logic [REG_ADDR_W-1:0]  id_rs2_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0]  ex_rs1_i,
    input  logic [REG_ADDR_W-1:0]  ex_rs2_i,
    input  logic [REG_ADDR_W-1:0]  ex_rd_i,
    input  logic                   ex_reg_write_i,
    input  logic                   ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0]  mem_rd_i,
    input  logic                   mem_reg_write_i,
    input  logic [REG_ADDR_W-1:0]  wb_rd_i,
    input  logic                   wb_reg_write_i,
    output logic [STALL_CNT_W-1:0] stall_n_o,
    output fwd_sel_t               fwd_a_o,
    output fwd_sel_t               fwd_b_o
);

    logic ex_hit;
    assign ex_hit = id_match(ex_rd_i, ex_reg_write_i, id_rs1_i, id_use_rs1_i,
                             id_rs2_i, id_use_rs2_i);

`ifdef PIPE_FORWARDING_EN
    // The younger EX/MEM result wins over MEM/WB when both write the same register.
    always_comb begin
        fwd_a_o = FWD_REG;
        fwd_b_o = FWD_REG;
        if (reg_match(mem_rd_i, mem_reg_write_i, ex_rs1_i)) begin
            fwd_a_o = FWD_MEM;
        end else if (reg_match(wb_rd_i, wb_reg_write_i, ex_rs1_i)) begin
            fwd_a_o = FWD_WB;
        end
        if (reg_match(mem_rd_i, mem_reg_write_i, ex_rs2_i)) begin
            fwd_b_o = FWD_MEM;
        end else if (reg_match(wb_rd_i, wb_reg_write_i, ex_rs2_i)) begin
            fwd_b_o = FWD_WB;
        end
        stall_n_o = (ex_mem_read_i && ex_hit) ? STALL_CNT_W'(1) : '0;
    end
`else
    logic mem_hit;
    logic wb_hit;
    logic unused_fwd_inputs;

    assign mem_hit = id_match(mem_rd_i, mem_reg_write_i, id_rs1_i, id_use_rs1_i,
                              id_rs2_i, id_use_rs2_i);
    assign wb_hit  = id_match(wb_rd_i, wb_reg_write_i, id_rs1_i, id_use_rs1_i,
                              id_rs2_i, id_use_rs2_i);
    assign unused_fwd_inputs = ^{ex_rs1_i, ex_rs2_i, ex_mem_read_i};

    assign fwd_a_o = FWD_REG;
    assign fwd_b_o = FWD_REG;

    // Register file is not write-through, so a WB producer still costs a cycle.
    always_comb begin
        stall_n_o = '0;
        if (ex_hit) begin
            stall_n_o = STALL_CNT_W'(3);
        end else if (mem_hit) begin
            stall_n_o = STALL_CNT_W'(2);
        end else if (wb_hit) begin
            stall_n_o = STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline sequencing: stall FSM, stage enable/flush decode, perf counters.
// Build option PIPE_FORWARDING_EN selects forwarding instead of full RAW stalls.
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned STALL_CNT_W = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    pipeline_hazard_controller_if.slave    pif,
    output logic [CNT_WIDTH-1:0]           stall_count_o,
    output logic [CNT_WIDTH-1:0]           flush_count_o,
    output logic [CNT_WIDTH-1:0]           cycle_count_o
);

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_n;
    fwd_sel_t               fwd_a, fwd_b;
    logic                   stall, stall_act, flush_act;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    pipe_hazard_detect #(
        .STALL_CNT_W (STALL_CNT_W)
    ) u_detect (
        .id_rs1_i        (pif.id_rs1),
        .id_rs2_i        (pif.id_rs2),
        .id_use_rs1_i    (pif.id_use_rs1),
        .id_use_rs2_i    (pif.id_use_rs2),
        .ex_rs1_i        (pif.ex_rs1),
        .ex_rs2_i        (pif.ex_rs2),
        .ex_rd_i         (pif.ex_rd),
        .ex_reg_write_i  (pif.ex_reg_write),
        .ex_mem_read_i   (pif.ex_mem_read),
        .mem_rd_i        (pif.mem_rd),
        .mem_reg_write_i (pif.mem_reg_write),
        .wb_rd_i         (pif.wb_rd),
        .wb_reg_write_i  (pif.wb_reg_write),
        .stall_n_o       (stall_n),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b)
    );

    // A taken branch overrides everything and aborts any stall in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (pif.branch_taken) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (stall_n != '0) begin
                        stall   = 1'b1;
                        cnt_d   = stall_n - STALL_CNT_W'(1);
                        state_d = (stall_n > STALL_CNT_W'(1)) ? StStall : StRun;
                    end
                end
                StStall: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - STALL_CNT_W'(1);
                    if (cnt_q == STALL_CNT_W'(1)) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Reset is synchronous; gate decode so outputs read idle while it is held.
    assign stall_act = stall & ~reset;
    assign flush_act = pif.branch_taken & ~reset;

    assign pif.pc_enable    = ~stall_act;
    assign pif.if_id_enable = ~stall_act;
    assign pif.if_id_flush  = flush_act;
    assign pif.id_ex_flush  = stall_act | flush_act;
    assign pif.ex_mem_flush = flush_act;
    assign pif.fwd_a        = reset ? FWD_REG : fwd_a;
    assign pif.fwd_b        = reset ? FWD_REG : fwd_b;

    always_comb begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        stall_cnt_d = stall_act ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_act ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;
    assign cycle_count_o = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: vector table plus reset/abort/saturation
// sequences. Expectations follow the build option PIPE_FORWARDING_EN.
module tb_pipeline_hazard_controller;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if pif ();
    pipeline_hazard_controller_if pif_s ();

    logic [31:0] stall_cnt, flush_cnt, cycle_cnt;
    logic [1:0]  s_stall, s_flush, s_cycle;

    pipeline_hazard_controller #(.CNT_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .pif           (pif),
        .stall_count_o (stall_cnt),
        .flush_count_o (flush_cnt),
        .cycle_count_o (cycle_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, to reach saturation quickly.
    pipeline_hazard_controller #(.CNT_WIDTH(2)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .pif           (pif_s),
        .stall_count_o (s_stall),
        .flush_count_o (s_flush),
        .cycle_count_o (s_cycle)
    );

    assign pif_s.id_rs1        = pif.id_rs1;
    assign pif_s.id_rs2        = pif.id_rs2;
    assign pif_s.id_use_rs1    = pif.id_use_rs1;
    assign pif_s.id_use_rs2    = pif.id_use_rs2;
    assign pif_s.ex_rs1        = pif.ex_rs1;
    assign pif_s.ex_rs2        = pif.ex_rs2;
    assign pif_s.ex_rd         = pif.ex_rd;
    assign pif_s.ex_reg_write  = pif.ex_reg_write;
    assign pif_s.ex_mem_read   = pif.ex_mem_read;
    assign pif_s.mem_rd        = pif.mem_rd;
    assign pif_s.mem_reg_write = pif.mem_reg_write;
    assign pif_s.wb_rd         = pif.wb_rd;
    assign pif_s.wb_reg_write  = pif.wb_reg_write;
    assign pif_s.branch_taken  = pif.branch_taken;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       use1, use2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_we, ex_mr;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        int         n_nofwd, n_fwd;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[15];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush}
    function automatic logic [31:0] ctl();
        return {27'd0, pif.pc_enable, pif.if_id_enable, pif.if_id_flush,
                pif.id_ex_flush, pif.ex_mem_flush};
    endfunction

    function automatic int min3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) cyc = 0;
        else cyc++;
        @(negedge clk);
    endtask

    task automatic set_idle();
        pif.id_rs1 = '0; pif.id_rs2 = '0; pif.id_use_rs1 = 0; pif.id_use_rs2 = 0;
        pif.ex_rs1 = '0; pif.ex_rs2 = '0; pif.ex_rd = '0;
        pif.ex_reg_write = 0; pif.ex_mem_read = 0;
        pif.mem_rd = '0; pif.mem_reg_write = 0;
        pif.wb_rd = '0; pif.wb_reg_write = 0;
        pif.branch_taken = 0;
    endtask

    task automatic apply(input vec_t v);
        pif.id_rs1 = v.rs1; pif.id_rs2 = v.rs2;
        pif.id_use_rs1 = v.use1; pif.id_use_rs2 = v.use2;
        pif.ex_rs1 = v.ex_rs1; pif.ex_rs2 = v.ex_rs2; pif.ex_rd = v.ex_rd;
        pif.ex_reg_write = v.ex_we; pif.ex_mem_read = v.ex_mr;
        pif.mem_rd = v.mem_rd; pif.mem_reg_write = v.mem_we;
        pif.wb_rd = v.wb_rd; pif.wb_reg_write = v.wb_we;
        pif.branch_taken = 0;
    endtask

    // Load in EX whose rd feeds ID rs1: three stalls without forwarding, one with.
    task automatic apply_load_use();
        set_idle();
        pif.ex_rd = 5'd5; pif.ex_reg_write = 1; pif.ex_mem_read = 1;
        pif.id_rs1 = 5'd5; pif.id_use_rs1 = 1;
    endtask

    initial begin
        //          rs1 rs2 u1 u2 exrs1 exrs2 exrd we mr memrd we wbrd we  N  Nf  fa  fb
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 2'd0};
        vecs[1]  = '{5'd5, 5'd0, 1, 0, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0, 3, 0, 2'd0, 2'd0};
        vecs[2]  = '{5'd0, 5'd0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 2'd0};
        vecs[3]  = '{5'd0, 5'd6, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 5'd6, 1, 5'd0, 0, 2, 0, 2'd0, 2'd0};
        vecs[4]  = '{5'd9, 5'd0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd9, 1, 1, 0, 2'd0, 2'd0};
        vecs[5]  = '{5'd5, 5'd0, 0, 0, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 2'd0};
        vecs[6]  = '{5'd5, 5'd0, 1, 0, 5'd0, 5'd0, 5'd5, 0, 0, 5'd5, 1, 5'd0, 0, 2, 0, 2'd0, 2'd0};
        vecs[7]  = '{5'd4, 5'd8, 1, 1, 5'd0, 5'd0, 5'd4, 1, 0, 5'd8, 1, 5'd0, 0, 3, 0, 2'd0, 2'd0};
        vecs[8]  = '{5'd0, 5'd7, 0, 1, 5'd0, 5'd0, 5'd7, 1, 1, 5'd0, 0, 5'd0, 0, 3, 1, 2'd0, 2'd0};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd7, 5'd0, 0, 0, 5'd7, 1, 5'd0, 0, 0, 0, 2'd0, 2'd1};
        vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd3, 5'd0, 5'd0, 0, 0, 5'd3, 1, 5'd3, 1, 0, 0, 2'd1, 2'd0};
        vecs[11] = '{5'd0, 5'd0, 0, 0, 5'd12, 5'd12, 5'd0, 0, 0, 5'd0, 0, 5'd12, 1, 0, 0, 2'd2, 2'd2};
        vecs[12] = '{5'd7, 5'd0, 0, 0, 5'd0, 5'd0, 5'd7, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 2'd0};
        vecs[13] = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd7, 5'd0, 0, 0, 5'd7, 0, 5'd0, 0, 0, 0, 2'd0, 2'd0};
        vecs[14] = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd0, 1, 0, 0, 2'd0, 2'd0};

        // Reset held three cycles with a hazard, a branch and a forwardable source present.
        reset = 1'b1;
        apply_load_use();
        pif.branch_taken = 1; pif.ex_rs1 = 5'd3; pif.mem_rd = 5'd3; pif.mem_reg_write = 1;
        repeat (3) tick();
        #1;
        check("reset_ctl", ctl(), 32'h18);
        check("reset_fwd_a", {30'd0, pif.fwd_a}, 32'd0);
        reset = 1'b0;
        set_idle();
        #1;
        check("idle_ctl", ctl(), 32'h18);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        check("reset_cycle_cnt", cycle_cnt, 32'd0);
        repeat (5) tick();
        check("cycle_cnt_5", cycle_cnt, 32'd5);

        // Stall started, then a taken branch in its second cycle aborts it.
        apply_load_use();
        #1;
        check("abort_stall1_ctl", ctl(), 32'h02);
        tick();
        set_idle();
        pif.branch_taken = 1;
        #1;
        check("abort_branch_ctl", ctl(), 32'h1f);
        tick();
        pif.branch_taken = 0;
        #1;
        check("abort_after_ctl", ctl(), 32'h18);
        exp_stall = 1;
        exp_flush = 1;
        check("abort_stall_cnt", stall_cnt, exp_stall);
        check("abort_flush_cnt", flush_cnt, exp_flush);

        // Branch held with a hazard present: branch wins every cycle, no stall starts.
        for (int k = 0; k < 3; k++) begin
            apply_load_use();
            pif.branch_taken = 1;
            #1;
            check("branch_hold_ctl", ctl(), 32'h1f);
            tick();
        end
        set_idle();
        #1;
        check("branch_release_ctl", ctl(), 32'h18);
        exp_flush += 3;
        check("branch_flush_cnt", flush_cnt, exp_flush);
        check("branch_stall_cnt", stall_cnt, exp_stall);

        // Vector table: first-cycle decode, forward selects, and total stall length.
        for (int i = 0; i < 15; i++) begin
            int n;
            int seen;
            logic [1:0] efa, efb;
`ifdef PIPE_FORWARDING_EN
            n = vecs[i].n_fwd; efa = vecs[i].fa; efb = vecs[i].fb;
`else
            n = vecs[i].n_nofwd; efa = 2'd0; efb = 2'd0;
`endif
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d_ctl", i), ctl(), (n != 0) ? 32'h02 : 32'h18);
            check($sformatf("vec%0d_fwd_a", i), {30'd0, pif.fwd_a}, {30'd0, efa});
            check($sformatf("vec%0d_fwd_b", i), {30'd0, pif.fwd_b}, {30'd0, efb});
            seen = pif.pc_enable ? 0 : 1;
            tick();
            set_idle();
            for (int k = 0; k < 5; k++) begin
                #1;
                if (!pif.pc_enable) seen++;
                tick();
            end
            check($sformatf("vec%0d_stall_len", i), seen, n);
            exp_stall += n;
            check($sformatf("vec%0d_stall_cnt", i), stall_cnt, exp_stall);
        end
        check("table_cycle_cnt", cycle_cnt, cyc);
        check("table_flush_cnt", flush_cnt, exp_flush);

        // Two-bit counters must have stuck at all-ones rather than wrapped.
        check("sat_cycle", {30'd0, s_cycle}, min3(cyc));
        check("sat_stall", {30'd0, s_stall}, min3(exp_stall));
        check("sat_flush", {30'd0, s_flush}, min3(exp_flush));
        apply_load_use();
        #1;
        tick();
        set_idle();
        #1;
        check("sat_stall_hold", {30'd0, s_stall}, min3(exp_stall + 1));

        // Reset asserted mid-stall: decode idles at once, RUN after the edge.
        apply_load_use();
        #1;
        tick();
        set_idle();
        reset = 1'b1;
        #1;
        check("midreset_ctl", ctl(), 32'h18);
        tick();
        reset = 1'b0;
        #1;
        check("postreset_ctl", ctl(), 32'h18);
        check("postreset_stall_cnt", stall_cnt, 32'd0);
        check("postreset_flush_cnt", flush_cnt, 32'd0);
        tick();
        check("postreset_cycle_cnt", cycle_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
